pcie_tx_arbiter: RTL and testbench
==================================

Name: pcie_tx_arbiter

Overview:
Packet-granular arbiter that shares the single PCIe Tx local-link (trn_t*) between two TLP sources.
- Requester A is the hugepage packet-write engine (posted memory writes).
- Requester B is a completion/read-request source, e.g. the MDIO/host-register completer.
- Sits between the endpoint core's Tx port and the sources. Round-robin grant, gated on core buffer availability, with a stall watchdog.

Parameters:
A_BUF_BIT, 1, index of trn_tbuf_av that must be 1 before A is eligible (posted buffer).
B_BUF_BIT, 2, index of trn_tbuf_av that must be 1 before B is eligible (completion buffer).
WD_LIMIT, 512, consecutive cycles a granted requester may hold tsrc_rdy_n high mid-packet before abort.
WD_W, 10, watchdog counter width; WD_LIMIT < 2^WD_W.

Ports:
trn_clk  in  1  clock; all logic on the rising edge
trn_reset_n  in  1  synchronous active-low reset
trn_tbuf_av  in  4  core Tx buffer availability
trn_tdst_rdy_n  in  1  core ready for the current beat
trn_tdst_dsc_n  in  1  core discontinue
trn_td  out  64  muxed data to core
trn_trem_n  out  8  muxed remainder
trn_tsof_n  out  1  muxed start-of-frame
trn_teof_n  out  1  muxed end-of-frame
trn_tsrc_rdy_n  out  1  muxed source ready
a_req  in  1  A has a TLP pending; held until a_gnt
a_gnt  out  1  A owns the link
a_td / a_trem_n / a_tsof_n / a_teof_n / a_tsrc_rdy_n  in  64/8/1/1/1  A local-link source
a_tdst_rdy_n  out  1  core ready, forwarded to A
b_req, b_gnt, b_td, b_trem_n, b_tsof_n, b_teof_n, b_tsrc_rdy_n, b_tdst_rdy_n  —  same as A, for B
tx_arb_err  out  1  sticky: watchdog or discontinue abort occurred
busy  out  1  high while in state BUSY

Behaviour:
- Reset (trn_reset_n=0 at an edge):
  - state=IDLE; a_gnt=b_gnt=0; busy=0; tx_arb_err=0; watchdog=0.
  - last_grant=B, so A wins the first tie.
  - A reset mid-packet abandons the packet. Grants are low the cycle after the reset edge.
- Eligibility:
  - elig_a = a_req & trn_tbuf_av[A_BUF_BIT].
  - elig_b = b_req & trn_tbuf_av[B_BUF_BIT].
- IDLE:
  - Core outputs are idle: trn_tsrc_rdy_n=1, trn_tsof_n=1, trn_teof_n=1, trn_td=0, trn_trem_n=0.
  - a_tdst_rdy_n=b_tdst_rdy_n=1.
  - If exactly one requester is eligible, grant it. If both are, grant the one not equal to last_grant.
  - The grant register is set at the edge and state goes to BUSY. Request-to-grant latency is 1 cycle.
- BUSY, selected requester S:
  - Core outputs are combinationally muxed from S's inputs.
  - s_tdst_rdy_n = trn_tdst_rdy_n; the other requester sees tdst_rdy_n=1.
  - Accepted beat = !s_tsrc_rdy_n & !trn_tdst_rdy_n.
  - Accepted beat with s_teof_n=0: at that edge clear the grant, set last_grant=S, go to IDLE.
  - There is one mandatory idle cycle between packets; back-to-back packets from one source need 2 cycles of grant turnaround.
  - Single-beat packets (sof and eof on the same beat) are legal.
- Grant stickiness:
  - The grant is held for the whole packet regardless of req, the other requester, or tbuf_av changes.
  - Eligibility is evaluated only in IDLE.
- Watchdog:
  - Counts cycles in BUSY with s_tsrc_rdy_n=1. It clears on any cycle with s_tsrc_rdy_n=0.
  - Core backpressure (trn_tdst_rdy_n=1) does not count.
  - On reaching WD_LIMIT: go to IDLE, drop the grant, set tx_arb_err=1, set last_grant=S.
- Discontinue: trn_tdst_dsc_n=0 in BUSY → same abort path as the watchdog.
- tx_arb_err clears only on reset.
- busy = (state==BUSY).
- Requesters must not drive tsrc_rdy_n=0 without their gnt; the arbiter ignores ungranted inputs.

Test Plan:
1. Reset, then a_req=1 with tbuf_av=4'b0010 → a_gnt=1 one cycle later. A sends a 3-beat TLP with tdst_rdy_n=0 → 3 beats appear on trn_td bit-exact; a_gnt drops the edge after the eof beat.
2. a_req=b_req=1 held, tbuf_av=4'hF, 4-beat packets each → grant order A,B,A,B; exactly one idle cycle (trn_tsrc_rdy_n=1, both gnt=0) between packets.
3. b_req=1, tbuf_av[2]=0 for 20 cycles, then 1 → b_gnt stays 0 for 20 cycles and asserts 1 cycle after tbuf_av[2] rises. a_req alone with tbuf_av[1]=1 is granted meanwhile.
4. A granted, trn_tdst_rdy_n=1 for 1000 cycles mid-packet → no abort, a_gnt held, tx_arb_err=0. A then stalls a_tsrc_rdy_n=1 for 512 cycles → grant dropped, tx_arb_err=1, and B is granted next if requesting.
5. trn_tdst_dsc_n pulsed 0 mid-packet of B → IDLE next cycle, tx_arb_err=1, next tie goes to A.
6. trn_reset_n=0 mid-packet for one edge → gnt=0, trn_tsrc_rdy_n=1, tx_arb_err=0 afterwards; the first tie after reset is granted to A.

Source files
------------

// File: rtl/pcie_tx_arbiter.sv
// pcie_tx_arbiter: packet-granular round-robin arbiter sharing one PCIe Tx
// local-link between a posted-write source (A) and a completion source (B).
// A grant is only issued when the matching core Tx buffer is available, is
// held for the whole TLP, and is torn down on eof, on discontinue, or when the
// granted source stalls for too long mid-packet.
module pcie_tx_arbiter #(
  parameter int A_BUF_BIT = 1,
  parameter int B_BUF_BIT = 2,
  parameter int WD_LIMIT  = 512,
  parameter int WD_W      = 10
) (
  input  logic        trn_clk,
  input  logic        trn_reset_n,
  input  logic [3:0]  trn_tbuf_av,
  input  logic        trn_tdst_rdy_n,
  input  logic        trn_tdst_dsc_n,
  output logic [63:0] trn_td,
  output logic [7:0]  trn_trem_n,
  output logic        trn_tsof_n,
  output logic        trn_teof_n,
  output logic        trn_tsrc_rdy_n,
  input  logic        a_req,
  output logic        a_gnt,
  input  logic [63:0] a_td,
  input  logic [7:0]  a_trem_n,
  input  logic        a_tsof_n,
  input  logic        a_teof_n,
  input  logic        a_tsrc_rdy_n,
  output logic        a_tdst_rdy_n,
  input  logic        b_req,
  output logic        b_gnt,
  input  logic [63:0] b_td,
  input  logic [7:0]  b_trem_n,
  input  logic        b_tsof_n,
  input  logic        b_teof_n,
  input  logic        b_tsrc_rdy_n,
  output logic        b_tdst_rdy_n,
  output logic        tx_arb_err,
  output logic        busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_sel;      // 0 = A owns the link, 1 = B
  logic              r_last;     // requester of the most recent packet (0 = A, 1 = B)
  logic              r_a_gnt;
  logic              r_b_gnt;
  logic              r_err;
  logic [WD_W-1:0]   r_wd;

  logic              w_elig_a;
  logic              w_elig_b;
  logic              w_pick_b;
  logic              w_s_tsrc_rdy_n;
  logic              w_s_teof_n;
  logic              w_accept;
  logic [WD_W-1:0]   w_wd_next;
  logic              w_wd_hit;
  logic              w_abort;
  logic              w_unused_tbuf;

  // Only two of the buffer-availability bits matter; the rest are folded away.
  assign w_unused_tbuf  = ^trn_tbuf_av;

  assign w_elig_a       = a_req & trn_tbuf_av[A_BUF_BIT];
  assign w_elig_b       = b_req & trn_tbuf_av[B_BUF_BIT];
  // On a tie, B wins only if A had the previous packet.
  assign w_pick_b       = w_elig_b & (~w_elig_a | ~r_last);

  assign w_s_tsrc_rdy_n = r_sel ? b_tsrc_rdy_n : a_tsrc_rdy_n;
  assign w_s_teof_n     = r_sel ? b_teof_n     : a_teof_n;
  assign w_accept       = ~w_s_tsrc_rdy_n & ~trn_tdst_rdy_n;

  // Watchdog counts only source stalls; core backpressure with data offered
  // resets it because the source is doing its part.
  assign w_wd_next      = r_wd + {{(WD_W-1){1'b0}}, 1'b1};
  assign w_wd_hit       = w_s_tsrc_rdy_n & (w_wd_next == WD_W'(WD_LIMIT));
  assign w_abort        = ~trn_tdst_dsc_n | w_wd_hit;

  // Grant FSM: pick in IDLE, hold through the packet, release on eof or abort.
  always_ff @(posedge trn_clk) begin
    if (!trn_reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= 1'b0;
      r_last  <= 1'b1;
      r_a_gnt <= 1'b0;
      r_b_gnt <= 1'b0;
      r_err   <= 1'b0;
      r_wd    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wd <= '0;
          if (w_elig_a | w_elig_b) begin
            r_state <= ST_BUSY;
            r_sel   <= w_pick_b;
            r_a_gnt <= ~w_pick_b;
            r_b_gnt <= w_pick_b;
          end
        end
        ST_BUSY: begin
          if (w_abort) begin
            r_state <= ST_IDLE;
            r_a_gnt <= 1'b0;
            r_b_gnt <= 1'b0;
            r_last  <= r_sel;
            r_err   <= 1'b1;
            r_wd    <= '0;
          end else if (w_accept & ~w_s_teof_n) begin
            r_state <= ST_IDLE;
            r_a_gnt <= 1'b0;
            r_b_gnt <= 1'b0;
            r_last  <= r_sel;
            r_wd    <= '0;
          end else if (w_s_tsrc_rdy_n) begin
            r_wd <= w_wd_next;
          end else begin
            r_wd <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_a_gnt <= 1'b0;
          r_b_gnt <= 1'b0;
        end
      endcase
    end
  end

  // Combinational data path: the owner's link drives the core, idle otherwise.
  always_comb begin
    trn_td         = '0;
    trn_trem_n     = '0;
    trn_tsof_n     = 1'b1;
    trn_teof_n     = 1'b1;
    trn_tsrc_rdy_n = 1'b1;
    a_tdst_rdy_n   = 1'b1;
    b_tdst_rdy_n   = 1'b1;
    if (r_state == ST_BUSY) begin
      if (r_sel) begin
        trn_td         = b_td;
        trn_trem_n     = b_trem_n;
        trn_tsof_n     = b_tsof_n;
        trn_teof_n     = b_teof_n;
        trn_tsrc_rdy_n = b_tsrc_rdy_n;
        b_tdst_rdy_n   = trn_tdst_rdy_n;
      end else begin
        trn_td         = a_td;
        trn_trem_n     = a_trem_n;
        trn_tsof_n     = a_tsof_n;
        trn_teof_n     = a_teof_n;
        trn_tsrc_rdy_n = a_tsrc_rdy_n;
        a_tdst_rdy_n   = trn_tdst_rdy_n;
      end
    end
  end

  assign a_gnt      = r_a_gnt;
  assign b_gnt      = r_b_gnt;
  assign tx_arb_err = r_err;
  assign busy       = (r_state == ST_BUSY);

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb_pcie_tx_arbiter: directed scenarios followed by random traffic, every
// cycle compared against a requester-indexed behavioural model.
module tb_pcie_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  tbuf = 4'h0;
  logic        tdst_rdy_n = 1'b1;
  logic        dsc_n = 1'b1;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [63:0] a_td = '0, b_td = '0;
  logic [7:0]  a_trem = '0, b_trem = '0;
  logic        a_sof = 1'b1, a_eof = 1'b1, a_src = 1'b1;
  logic        b_sof = 1'b1, b_eof = 1'b1, b_src = 1'b1;

  wire [63:0]  trn_td;
  wire [7:0]   trn_trem_n;
  wire         trn_tsof_n, trn_teof_n, trn_tsrc_rdy_n;
  wire         a_gnt, b_gnt, a_tdst_rdy_n, b_tdst_rdy_n, tx_arb_err, busy;

  pcie_tx_arbiter dut (
    .trn_clk(clk), .trn_reset_n(rst_n), .trn_tbuf_av(tbuf),
    .trn_tdst_rdy_n(tdst_rdy_n), .trn_tdst_dsc_n(dsc_n),
    .trn_td(trn_td), .trn_trem_n(trn_trem_n), .trn_tsof_n(trn_tsof_n),
    .trn_teof_n(trn_teof_n), .trn_tsrc_rdy_n(trn_tsrc_rdy_n),
    .a_req(a_req), .a_gnt(a_gnt), .a_td(a_td), .a_trem_n(a_trem),
    .a_tsof_n(a_sof), .a_teof_n(a_eof), .a_tsrc_rdy_n(a_src),
    .a_tdst_rdy_n(a_tdst_rdy_n),
    .b_req(b_req), .b_gnt(b_gnt), .b_td(b_td), .b_trem_n(b_trem),
    .b_tsof_n(b_sof), .b_teof_n(b_eof), .b_tsrc_rdy_n(b_src),
    .b_tdst_rdy_n(b_tdst_rdy_n),
    .tx_arb_err(tx_arb_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: who owns the link (-1 none, 0 A, 1 B), who owned it last,
  // how long the owner has been stalled, and the sticky error flag.
  int m_owner = -1;
  int m_last  = 1;
  int m_stall = 0;
  bit m_err   = 1'b0;

  function automatic logic [127:0] dut_vec();
    logic [127:0] v;
    v = '0;
    v[80:0] = {a_gnt, b_gnt, busy, tx_arb_err, trn_tsrc_rdy_n, trn_tsof_n,
               trn_teof_n, a_tdst_rdy_n, b_tdst_rdy_n, trn_trem_n, trn_td};
    return v;
  endfunction

  function automatic logic [127:0] exp_vec();
    logic [127:0] v;
    logic [63:0]  td   [2];
    logic [7:0]   trem [2];
    logic         src[2], sof[2], eof[2], dst[2];
    td[0] = a_td;   td[1] = b_td;
    trem[0] = a_trem; trem[1] = b_trem;
    src[0] = a_src; src[1] = b_src;
    sof[0] = a_sof; sof[1] = b_sof;
    eof[0] = a_eof; eof[1] = b_eof;
    dst[0] = 1'b1;  dst[1] = 1'b1;
    v = '0;
    if (m_owner < 0) begin
      v[80:0] = {1'b0, 1'b0, 1'b0, m_err, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 64'h0};
    end else begin
      dst[m_owner] = tdst_rdy_n;
      v[80:0] = {m_owner == 0, m_owner == 1, 1'b1, m_err, src[m_owner], sof[m_owner],
                 eof[m_owner], dst[0], dst[1], trem[m_owner], td[m_owner]};
    end
    return v;
  endfunction

  task automatic model_update();
    logic src[2], eof[2];
    int   stall_new;
    src[0] = a_src; src[1] = b_src;
    eof[0] = a_eof; eof[1] = b_eof;
    if (!rst_n) begin
      m_owner = -1; m_last = 1; m_stall = 0; m_err = 1'b0;
    end else if (m_owner < 0) begin
      bit ea, eb;
      ea = a_req & tbuf[1];
      eb = b_req & tbuf[2];
      if (ea && eb)  m_owner = (m_last == 0) ? 1 : 0;
      else if (ea)   m_owner = 0;
      else if (eb)   m_owner = 1;
      m_stall = 0;
    end else begin
      stall_new = src[m_owner] ? m_stall + 1 : 0;
      if (!dsc_n || stall_new >= 512) begin
        m_last = m_owner; m_owner = -1; m_stall = 0; m_err = 1'b1;
      end else if (!src[m_owner] && !tdst_rdy_n && !eof[m_owner]) begin
        m_last = m_owner; m_owner = -1; m_stall = 0;
      end else begin
        m_stall = stall_new;
      end
    end
  endtask

  // One clock: compare all outputs, advance both DUT and model, stop at negedge.
  task automatic step();
    #1;
    check_val("cycle", dut_vec(), exp_vec());
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_srcs();
    a_src = 1'b1; a_sof = 1'b1; a_eof = 1'b1;
    b_src = 1'b1; b_sof = 1'b1; b_eof = 1'b1;
    a_td = {$urandom, $urandom}; b_td = {$urandom, $urandom};
  endtask

  // Drive an n-beat packet on source s with the core always ready.
  task automatic send(int s, int n);
    logic [63:0] beat;
    for (int i = 0; i < n; i++) begin
      beat = {$urandom, $urandom};
      if (s == 0) begin
        a_src = 1'b0; a_sof = (i != 0); a_eof = (i != n - 1); a_td = beat; a_trem = 8'($urandom);
      end else begin
        b_src = 1'b0; b_sof = (i != 0); b_eof = (i != n - 1); b_td = beat; b_trem = 8'($urandom);
      end
      #1;
      check_val("beat_td", 128'(trn_td), 128'(beat));
      step();
    end
    idle_srcs();
  endtask

  task automatic wait_grant(output int who);
    who = -1;
    for (int i = 0; i < 64 && who < 0; i++) begin
      if (a_gnt)      who = 0;
      else if (b_gnt) who = 1;
      else            step();
    end
    if (who < 0) check_val("grant_timeout", 128'(0), 128'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int who;
    tdst_rdy_n = 1'b0;
    idle_srcs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    step();                                   // reset state check under reset
    rst_n = 1'b1;
    check_val("rst_gnt", 128'({a_gnt, b_gnt, busy, tx_arb_err}), 128'(0));

    // 1: single requester, 3-beat packet
    a_req = 1'b1; tbuf = 4'b0010;
    step();
    check_val("t1_gnt", 128'(a_gnt), 128'(1));
    a_req = 1'b0;
    send(0, 3);
    check_val("t1_drop", 128'(a_gnt), 128'(0));

    // 2: both requesting, alternate A,B,A,B with one idle cycle between
    rst_n = 1'b0; step(); rst_n = 1'b1;
    a_req = 1'b1; b_req = 1'b1; tbuf = 4'hF;
    for (int k = 0; k < 4; k++) begin
      wait_grant(who);
      check_val("t2_order", 128'(who), 128'(k % 2));
      send(who, 4);
      check_val("t2_gap", 128'({a_gnt, b_gnt, trn_tsrc_rdy_n}), 128'(3'b001));
    end
    a_req = 1'b0; b_req = 1'b0;
    step();

    // 3: B blocked on its buffer bit; A served meanwhile
    b_req = 1'b1; tbuf = 4'b0000;
    repeat (20) step();
    check_val("t3_blocked", 128'(b_gnt), 128'(0));
    a_req = 1'b1; tbuf = 4'b0010;
    step();
    check_val("t3_a_gnt", 128'(a_gnt), 128'(1));
    a_req = 1'b0;
    send(0, 1);
    tbuf = 4'b0110;
    step();
    check_val("t3_b_gnt", 128'(b_gnt), 128'(1));
    b_req = 1'b0;
    send(1, 2);

    // 4: long core backpressure is fine, a source stall of WD_LIMIT aborts
    a_req = 1'b1; tbuf = 4'hF;
    step();
    a_req = 1'b0;
    a_src = 1'b0; a_sof = 1'b0; a_eof = 1'b1; tdst_rdy_n = 1'b1;
    repeat (1000) step();
    check_val("t4_bp_gnt", 128'({a_gnt, tx_arb_err}), 128'(2'b10));
    tdst_rdy_n = 1'b0;
    step();                                   // sof beat accepted
    a_src = 1'b1; b_req = 1'b1; a_req = 1'b1;
    repeat (511) step();
    check_val("t4_pre_wd", 128'({a_gnt, tx_arb_err}), 128'(2'b10));
    step();
    check_val("t4_wd", 128'({a_gnt, tx_arb_err}), 128'(2'b01));
    step();
    check_val("t4_b_next", 128'({a_gnt, b_gnt}), 128'(2'b01));

    // 5: discontinue mid-packet of B
    a_req = 1'b0; b_req = 1'b0;
    b_src = 1'b0; b_sof = 1'b0; b_eof = 1'b1;
    step();
    b_src = 1'b1; dsc_n = 1'b0;
    step();
    dsc_n = 1'b1;
    check_val("t5_dsc", 128'({b_gnt, busy, tx_arb_err}), 128'(3'b001));
    a_req = 1'b1; b_req = 1'b1;
    step();
    check_val("t5_tie_a", 128'({a_gnt, b_gnt}), 128'(2'b10));

    // 6: reset mid-packet
    a_src = 1'b0; a_sof = 1'b0; a_eof = 1'b1;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; idle_srcs();
    check_val("t6_rst", 128'({a_gnt, b_gnt, trn_tsrc_rdy_n, tx_arb_err}), 128'(4'b0010));
    step();
    check_val("t6_tie_a", 128'({a_gnt, b_gnt}), 128'(2'b10));
    send(0, 1);
    a_req = 1'b0; b_req = 1'b0;
    step();

    // Random traffic, including ungranted garbage, dsc pulses and resets
    for (int c = 0; c < 4000; c++) begin
      rst_n      = ($urandom % 500) != 0;
      tbuf       = 4'($urandom);
      a_req      = ($urandom % 4) != 0;
      b_req      = ($urandom % 4) != 0;
      tdst_rdy_n = ($urandom % 4) == 0;
      dsc_n      = ($urandom % 200) != 0;
      a_src      = ($urandom % 3) == 0;
      b_src      = ($urandom % 3) == 0;
      a_sof      = 1'($urandom); b_sof = 1'($urandom);
      a_eof      = ($urandom % 4) != 0;
      b_eof      = ($urandom % 4) != 0;
      a_td       = {$urandom, $urandom}; b_td = {$urandom, $urandom};
      a_trem     = 8'($urandom); b_trem = 8'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
